// File: rtl/spi_frame_slave.sv
// SPI frame slave: oversampled SPI receiver/transmitter with frame-length and
// message-ID checking, a wrapping valid-frame counter and an optional watchdog.
module spi_frame_slave #(
  parameter int          BUFFER_SIZE = 64,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter int          CPOL        = 0,
  parameter int          CPHA        = 0,
  parameter logic [31:0] TIMEOUT     = 32'd0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sclk,
  input  logic                   sel,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   sync,
  output logic                   err_len,
  output logic                   err_id,
  output logic                   timeout,
  output logic [15:0]            frame_cnt
);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  localparam logic [15:0] FRAME_LEN = 16'(BUFFER_SIZE);
  localparam logic        SCLK_IDLE = (CPOL != 0);

  state_t                 state_q, state_d;
  logic [2:0]             sclk_s_q, sel_s_q;
  // Only stages 0 and 1 of the mosi synchroniser are ever observed.
  logic [1:0]             mosi_s_q;
  logic [BUFFER_SIZE-1:0] rx_sh_q, rx_sh_d;
  logic [BUFFER_SIZE-1:0] tx_sh_q, tx_sh_d;
  logic [BUFFER_SIZE-1:0] rx_data_q, rx_data_d;
  logic [15:0]            bit_cnt_q, bit_cnt_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [31:0]            wd_q, wd_d;
  logic                   first_q, first_d;
  logic                   late_q, late_d;
  logic                   sync_q, sync_d;
  logic                   err_len_q, err_len_d;
  logic                   err_id_q, err_id_d;

  logic sclk_rise, sclk_fall, sel_rise, sel_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign sclk_rise   = sclk_s_q[1] & ~sclk_s_q[2];
  assign sclk_fall   = ~sclk_s_q[1] & sclk_s_q[2];
  assign sel_rise    = sel_s_q[1] & ~sel_s_q[2];
  assign sel_fall    = ~sel_s_q[1] & sel_s_q[2];
  assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s_q <= {3{SCLK_IDLE}};
      sel_s_q  <= 3'b111;
      mosi_s_q <= 2'b00;
    end else begin
      sclk_s_q <= {sclk_s_q[1:0], sclk};
      sel_s_q  <= {sel_s_q[1:0], sel};
      mosi_s_q <= {mosi_s_q[0], mosi};
    end
  end

  always_comb begin
    state_d     = state_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    first_d     = first_q;
    late_d      = late_q;
    sync_d      = 1'b0;
    err_len_d   = 1'b0;
    err_id_d    = 1'b0;
    wd_d        = wd_q;
    if (sync_q) wd_d = '0;
    else if (wd_q != '1) wd_d = wd_q + 32'd1;

    case (state_q)
      IDLE: begin
        late_d = 1'b0;
        // A start seen during CHECK is honoured only if sel is still low.
        if (sel_fall || (late_q && !sel_s_q[1])) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          tx_sh_d   = tx_data;
          first_d   = 1'b1;
        end
      end
      SHIFT: begin
        if (sel_rise) begin
          // Status is registered here so it is visible during the CHECK cycle.
          state_d = CHECK;
          if (bit_cnt_q != FRAME_LEN) begin
            err_len_d = 1'b1;
          end else if (rx_sh_q[BUFFER_SIZE-1 -: 32] != MSGID) begin
            err_id_d = 1'b1;
          end else begin
            sync_d      = 1'b1;
            rx_data_d   = rx_sh_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else begin
          if (sample_edge) begin
            rx_sh_d = {rx_sh_q[BUFFER_SIZE-2:0], mosi_s_q[1]};
            if (bit_cnt_q != 16'hFFFF) bit_cnt_d = bit_cnt_q + 16'd1;
          end
          if (shift_edge) begin
            if ((CPHA != 0) && first_q) first_d = 1'b0;
            else tx_sh_d = {tx_sh_q[BUFFER_SIZE-2:0], 1'b0};
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        late_d  = sel_fall;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      wd_q        <= '0;
      first_q     <= 1'b0;
      late_q      <= 1'b0;
      sync_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      wd_q        <= wd_d;
      first_q     <= first_d;
      late_q      <= late_d;
      sync_q      <= sync_d;
      err_len_q   <= err_len_d;
      err_id_q    <= err_id_d;
    end
  end

  assign miso      = (state_q == SHIFT) & tx_sh_q[BUFFER_SIZE-1];
  assign rx_data   = rx_data_q;
  assign sync      = sync_q;
  assign err_len   = err_len_q;
  assign err_id    = err_id_q;
  assign frame_cnt = frame_cnt_q;
  assign timeout   = (TIMEOUT != 32'd0) && (wd_q >= TIMEOUT);
endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: one instance per SPI mode, all with a
// 1000-cycle watchdog, driven as an SPI master one frame at a time.
module tb_spi_frame_slave;
  localparam int          H    = 8;
  localparam logic [63:0] TX   = 64'hA5A5_0000_FFFF_0001;
  localparam logic [63:0] GOOD = 64'h74697277_12345678;
  localparam logic [63:0] BADID = 64'h00000000_12345678;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tx_data_r;
  logic        sclk_r [4];
  logic        sel_r [4];
  logic        mosi_r [4];
  logic        miso_w [4];
  logic        sync_w [4];
  logic        err_len_w [4];
  logic        err_id_w [4];
  logic        timeout_w [4];
  logic [63:0] rx_data_w [4];
  logic [15:0] frame_cnt_w [4];
  int          n_total = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    spi_frame_slave #(
      .BUFFER_SIZE(64),
      .MSGID(32'h74697277),
      .CPOL(gi / 2),
      .CPHA(gi % 2),
      .TIMEOUT(32'd1000)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .sclk(sclk_r[gi]),
      .sel(sel_r[gi]),
      .mosi(mosi_r[gi]),
      .miso(miso_w[gi]),
      .tx_data(tx_data_r),
      .rx_data(rx_data_w[gi]),
      .sync(sync_w[gi]),
      .err_len(err_len_w[gi]),
      .err_id(err_id_w[gi]),
      .timeout(timeout_w[gi]),
      .frame_cnt(frame_cnt_w[gi])
    );
  end

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_begin(input int m);
    tx_data_r = TX;
    sel_r[m]  = 1'b0;
    wait_clk(H);
  endtask

  // Sends n bits MSB first; captures miso just before each master sample edge.
  // tx_data is disturbed mid-frame to show the reply was latched at start.
  task automatic send_bits(input int m, input int n, input logic [127:0] data,
                           output logic [127:0] cap);
    logic cpol, cpha, b;
    cpol = ((m / 2) != 0);
    cpha = ((m % 2) != 0);
    cap  = '0;
    for (int i = 0; i < n; i++) begin
      b = data[n-1-i];
      if (i == 10) tx_data_r = 64'hDEAD_BEEF_0BAD_F00D;
      if (!cpha) begin
        mosi_r[m] = b;
        wait_clk(H);
        cap = {cap[126:0], miso_w[m]};
        sclk_r[m] = ~cpol;
        wait_clk(H);
        sclk_r[m] = cpol;
      end else begin
        sclk_r[m] = ~cpol;
        mosi_r[m] = b;
        wait_clk(H);
        cap = {cap[126:0], miso_w[m]};
        sclk_r[m] = cpol;
        wait_clk(H);
      end
    end
    wait_clk(H);
  endtask

  // kind: 0 = sync expected, 1 = err_len expected, 2 = err_id expected
  task automatic frame_end(input int m, input int kind, input string tag,
                           output logic tmo_at, output logic tmo_after);
    int ns, nl, ni, first;
    logic prev;
    ns = 0; nl = 0; ni = 0; first = -1; prev = 1'b0;
    tmo_at = 1'b0; tmo_after = 1'b1;
    sel_r[m] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (prev) tmo_after = timeout_w[m];
      if (sync_w[m]) tmo_at = timeout_w[m];
      prev = sync_w[m];
      if ((sync_w[m] || err_len_w[m] || err_id_w[m]) && first < 0) first = c;
      if (sync_w[m]) ns++;
      if (err_len_w[m]) nl++;
      if (err_id_w[m]) ni++;
    end
    chk_eq({tag, ".sync_cycles"}, 128'(ns), 128'(kind == 0));
    chk_eq({tag, ".err_len_cycles"}, 128'(nl), 128'(kind == 1));
    chk_eq({tag, ".err_id_cycles"}, 128'(ni), 128'(kind == 2));
    chk_eq({tag, ".pulse_latency"}, 128'(first), 128'(2));
    wait_clk(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [127:0] cap;
    logic ta, taf;
    string tag;
    rst_n = 1'b0;
    tx_data_r = TX;
    for (int m = 0; m < 4; m++) begin
      sclk_r[m] = ((m / 2) != 0);
      sel_r[m]  = 1'b1;
      mosi_r[m] = 1'b0;
    end
    wait_clk(3);
    for (int m = 0; m < 4; m++) begin
      tag = $sformatf("reset.mode%0d", m);
      chk_eq({tag, ".rx_data"}, 128'(rx_data_w[m]), 128'(0));
      chk_eq({tag, ".status"}, 128'({frame_cnt_w[m], miso_w[m], sync_w[m], err_len_w[m],
                                     err_id_w[m], timeout_w[m]}), 128'(0));
    end
    $display("reset applied, outputs checked");

    rst_n = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (k == 999) chk_eq("timeout.before_1000", 128'(timeout_w[0]), 128'(0));
      if (k == 1000) chk_eq("timeout.at_1000", 128'(timeout_w[0]), 128'(1));
    end
    $display("watchdog idle run: timeout=%0b after 1000 cycles", timeout_w[0]);

    for (int m = 0; m < 4; m++) begin
      tag = $sformatf("valid.mode%0d", m);
      frame_begin(m);
      send_bits(m, 64, {64'h0, GOOD}, cap);
      frame_end(m, 0, tag, ta, taf);
      chk_eq({tag, ".rx_data"}, 128'(rx_data_w[m]), 128'(GOOD));
      chk_eq({tag, ".frame_cnt"}, 128'(frame_cnt_w[m]), 128'(1));
      chk_eq({tag, ".miso_bits"}, cap, 128'(TX));
      chk_eq({tag, ".timeout_at_sync"}, 128'(ta), 128'(1));
      chk_eq({tag, ".timeout_after_sync"}, 128'(taf), 128'(0));
      $display("frame %s rx=%h miso=%h cnt=%0d", tag, rx_data_w[m], cap[63:0], frame_cnt_w[m]);
    end

    frame_begin(0);
    send_bits(0, 63, {65'h0, GOOD[62:0]}, cap);
    frame_end(0, 1, "len63", ta, taf);
    chk_eq("len63.rx_data", 128'(rx_data_w[0]), 128'(GOOD));
    chk_eq("len63.frame_cnt", 128'(frame_cnt_w[0]), 128'(1));
    $display("frame len63 rx=%h cnt=%0d", rx_data_w[0], frame_cnt_w[0]);

    frame_begin(0);
    send_bits(0, 65, {63'h0, 1'b1, GOOD}, cap);
    frame_end(0, 1, "len65", ta, taf);
    chk_eq("len65.rx_data", 128'(rx_data_w[0]), 128'(GOOD));
    chk_eq("len65.frame_cnt", 128'(frame_cnt_w[0]), 128'(1));
    $display("frame len65 rx=%h cnt=%0d", rx_data_w[0], frame_cnt_w[0]);

    frame_begin(0);
    send_bits(0, 64, {64'h0, BADID}, cap);
    frame_end(0, 2, "badid", ta, taf);
    chk_eq("badid.rx_data", 128'(rx_data_w[0]), 128'(GOOD));
    chk_eq("badid.frame_cnt", 128'(frame_cnt_w[0]), 128'(1));
    $display("frame badid rx=%h cnt=%0d", rx_data_w[0], frame_cnt_w[0]);

    frame_begin(0);
    send_bits(0, 20, {64'h0, GOOD}, cap);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_mid.outputs", 128'({rx_data_w[0], frame_cnt_w[0], miso_w[0], sync_w[0],
                                     err_len_w[0], err_id_w[0], timeout_w[0]}), 128'(0));
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(H);
    frame_end(0, 1, "rst_partial", ta, taf);
    chk_eq("rst_partial.frame_cnt", 128'(frame_cnt_w[0]), 128'(0));
    chk_eq("rst_partial.rx_data", 128'(rx_data_w[0]), 128'(0));
    $display("frame rst_partial rx=%h cnt=%0d", rx_data_w[0], frame_cnt_w[0]);

    frame_begin(0);
    send_bits(0, 64, {64'h0, GOOD}, cap);
    frame_end(0, 0, "post_rst", ta, taf);
    chk_eq("post_rst.rx_data", 128'(rx_data_w[0]), 128'(GOOD));
    chk_eq("post_rst.frame_cnt", 128'(frame_cnt_w[0]), 128'(1));
    chk_eq("post_rst.miso_bits", cap, 128'(TX));
    $display("frame post_rst rx=%h miso=%h cnt=%0d", rx_data_w[0], cap[63:0], frame_cnt_w[0]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_frame_slave.md
SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 64, frame length in bits (>=32).
REQ-002 SHALL have parameter MSGID, default 32'h74697277, required value of frame bits [BUFFER_SIZE-1:BUFFER_SIZE-32].
REQ-003 SHALL have parameter CPOL, default 0, SCLK idle level.
REQ-004 SHALL have parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have parameter TIMEOUT, default 32'd0, clk cycles without a valid frame before timeout; 0 disables.
REQ-006 SHALL have port clk  in  1  system clock; the only clock.
REQ-007 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports sclk, sel, mosi  in  1 each  SPI clock, active-low select, master data.
REQ-009 SHALL have port miso  out  1  slave data, MSB first.
REQ-010 SHALL have port tx_data  in  BUFFER_SIZE  reply frame.
REQ-011 SHALL have port rx_data  out  BUFFER_SIZE  last valid received frame.
REQ-012 SHALL have ports sync, err_len, err_id  out  1 each  one-cycle status pulses.
REQ-013 SHALL have port timeout  out  1  level, watchdog expired.
REQ-014 SHALL have port frame_cnt  out  16  count of valid frames, wraps.

Function
REQ-015 SHALL synchronise sclk, sel, mosi through 3-stage shift registers; edges from stages [2:1]; mosi sampled from stage 1.
REQ-016 SHALL define leading edge = rising if CPOL=0, falling if CPOL=1; sample edge = leading if CPHA=0, else trailing; shift edge = the other.
REQ-017 SHALL implement states IDLE, SHIFT, CHECK.
REQ-018 IDLE -> SHIFT on synchronised sel falling edge; bit counter cleared; tx shift register loaded with tx_data.
REQ-019 In SHIFT, each sample edge SHALL shift mosi into the rx shift register LSB side and increment the 16-bit bit counter, saturating at 16'hFFFF.
REQ-020 In SHIFT, each shift edge SHALL shift the tx register left, zero-filling; with CPHA=1 the first shift edge of a frame SHALL not shift.
REQ-021 miso SHALL equal tx register MSB while in SHIFT, 0 otherwise.
REQ-022 tx_data changes after frame start SHALL not affect the current frame.
REQ-023 SHIFT -> CHECK on synchronised sel rising edge; an sclk edge detected in the same cycle SHALL be ignored.
REQ-024 CHECK SHALL last exactly one cycle, then IDLE.
REQ-025 In CHECK, if bit count == BUFFER_SIZE and ID field == MSGID: rx_data <= rx shift register, sync = 1, frame_cnt += 1 (wrap 16'hFFFF -> 0), watchdog cleared.
REQ-026 In CHECK, if bit count != BUFFER_SIZE: err_len = 1, rx_data unchanged; length error takes priority over ID error.
REQ-027 In CHECK, if length correct and ID mismatched: err_id = 1, rx_data unchanged.
REQ-028 sync, err_len, err_id SHALL assert one cycle after the cycle in which sel rising edge is detected, for exactly one clk cycle, mutually exclusive.
REQ-029 If TIMEOUT != 0, the watchdog SHALL count clk cycles since reset or last sync, saturate, and assert timeout when count >= TIMEOUT; timeout SHALL clear in the cycle after sync.
REQ-030 A sel falling edge in CHECK SHALL be acted on in the following IDLE cycle only if sel is still low (frame started late, counted normally).

Reset
REQ-031 On rst_n low: state IDLE; rx_data, shift registers, bit counter, frame_cnt, watchdog = 0; sync, err_len, err_id, timeout, miso = 0; sel synchroniser = all 1; sclk synchroniser = CPOL.
REQ-032 Reset mid-frame SHALL discard the frame with no status pulse; if sel is low at release, the partial frame SHALL start and be rejected by the length check.

Verification
REQ-033 Mode 0, 64-bit frame with MSGID 32'h74697277 and payload 32'h12345678, tx_data=64'hA5A5_0000_FFFF_0001 -> rx_data=64'h74697277_12345678, sync pulse, frame_cnt=1, miso bits match tx_data MSB-first.
REQ-034 Repeat REQ-033 for modes 1, 2, 3 -> identical rx_data and miso bit stream.
REQ-035 63-bit and 65-bit frames -> err_len pulse, rx_data unchanged, frame_cnt unchanged.
REQ-036 64-bit frame with ID 32'h00000000 -> err_id pulse, no sync.
REQ-037 TIMEOUT=1000, no frames -> timeout high from cycle 1000; valid frame -> timeout low the cycle after sync.
REQ-038 rst_n asserted after 20 bits of a frame -> all outputs 0 immediately; next full valid frame -> sync, frame_cnt=1.
